// File: rtl/tensor_core_seq.sv
// Sequencer for a combinational 4x4x4 bf16 tensor core: runs a K-deep tiled
// accumulation D = sum(A*B) + C and hands back the final fp32 tile.
module tensor_core_seq #(
    parameter int unsigned TC_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   k_steps,
    input  logic [511:0] c_init,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] a_tile,
    input  logic [255:0] b_tile,
    output logic [255:0] tc_a,
    output logic [255:0] tc_b,
    output logic [511:0] tc_c,
    input  logic [511:0] tc_d,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] d_out,
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StWaitOp, StCompute, StDrain} state_e;

    localparam logic [3:0] LatLoad = 4'(TC_LAT - 1);

    state_e         state_q;
    logic [511:0]   acc_q;
    logic [255:0]   opa_q;
    logic [255:0]   opb_q;
    logic [7:0]     rem_q;
    logic [3:0]     lat_cnt_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic           busy_q;

    // opa/opb/acc only change on state exits, so the core path sees stable
    // operands for the whole TC_LAT-cycle COMPUTE window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            rem_q       <= '0;
            lat_cnt_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        acc_q  <= c_init;
                        rem_q  <= k_steps;
                        busy_q <= 1'b1;
                        if (k_steps == 8'd0) begin
                            state_q     <= StDrain;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q    <= StWaitOp;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                StWaitOp: begin
                    if (in_valid) begin
                        opa_q      <= a_tile;
                        opb_q      <= b_tile;
                        lat_cnt_q  <= LatLoad;
                        state_q    <= StCompute;
                        in_ready_q <= 1'b0;
                    end
                end
                StCompute: begin
                    if (lat_cnt_q == 4'd0) begin
                        acc_q <= tc_d;
                        rem_q <= rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            state_q     <= StDrain;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q    <= StWaitOp;
                            in_ready_q <= 1'b1;
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end
                end
                StDrain: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign tc_a      = opa_q;
    assign tc_b      = opb_q;
    assign tc_c      = acc_q;
    assign d_out     = acc_q;

endmodule
